logic_probe_sequencer: RTL and testbench
========================================

LOGIC_PROBE_SEQUENCER -- requirements
Module: logic_probe_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, meaning number of probe registers read per capture (addresses 0..NUM_REGS-1, range 1..5).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning ready-wait limit in clk cycles (used only when LOGIC_PROBE_SEQ_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  high permits new capture sequences.
REQ-006 SHALL have port probe_interrupt  input  1  probe measurement-period-complete flag (level).
REQ-007 SHALL have port probe_interrupt_clear  output  1  one-cycle pulse restarting the probe period.
REQ-008 SHALL have port probe_address  output  3  probe register select.
REQ-009 SHALL have port probe_data_request  output  1  one-cycle read strobe to probe.
REQ-010 SHALL have port probe_data_ready  input  1  probe read-complete strobe.
REQ-011 SHALL have port probe_data  input  32  probe read data, valid when probe_data_ready is high.
REQ-012 SHALL have port host_address  input  3  host register select.
REQ-013 SHALL have port host_read  input  1  host read strobe.
REQ-014 SHALL have port host_data  output  32  host read data, valid when host_ready is high.
REQ-015 SHALL have port host_ready  output  1  host read-complete strobe.
REQ-016 SHALL have port host_ack  input  1  host pulse: clears result_valid and overrun.
REQ-017 SHALL have port result_valid  output  1  a completed snapshot is unacknowledged.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, CLEAR.
REQ-019 IDLE SHALL go to REQ with index=0 when enable=1 and probe_interrupt=1.
REQ-020 REQ SHALL drive probe_data_request=1 and probe_address=index for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL, when probe_data_ready=1, write probe_data into shadow[index]; if index==NUM_REGS-1 go to CLEAR, else increment index and go to REQ.
REQ-022 CLEAR SHALL drive probe_interrupt_clear=1 for one cycle, copy all shadow words into the host bank in that same cycle, set result_valid, increment the 16-bit capture_count (wraps 0xFFFF->0), then go to IDLE.
REQ-023 After CLEAR, IDLE SHALL ignore probe_interrupt for one cycle so a stale flag cannot retrigger.
REQ-024 Deasserting enable mid-sequence SHALL NOT abort it; the sequence completes and the FSM then stays in IDLE.
REQ-025 If result_valid=1 when CLEAR is reached, the bank SHALL be overwritten and sticky overrun SHALL be set.
REQ-026 host_ack and CLEAR in the same cycle SHALL leave result_valid=1 and overrun unchanged, since CLEAR wins.
REQ-027 A host_read SHALL produce host_ready=1 on the next cycle with host_data latched: addresses 0..NUM_REGS-1 return the bank word; 5 returns {12'h0, error, overrun, result_valid, enable, capture_count}; 6 and 7 return 0.
REQ-028 Host reads SHALL never stall and SHALL never observe a partially updated bank.
REQ-029 probe_address SHALL hold index in every state; it is 0 in IDLE.

Reset
REQ-030 nreset=0 SHALL asynchronously force state=IDLE, index=0, probe_data_request=0, probe_interrupt_clear=0, host_ready=0, host_data=0, result_valid=0, overrun=0, error=0, capture_count=0, and all shadow and bank words to 0.
REQ-031 Reset mid-sequence SHALL discard partial data; the next sequence starts only when probe_interrupt is observed after release.

Configuration
REQ-032 With LOGIC_PROBE_SEQ_TIMEOUT_EN defined: in WAIT, if TIMEOUT_CYCLES cycles elapse with no probe_data_ready, SHALL write 32'hFFFFFFFF to shadow[index], set sticky error (cleared by host_ack or reset), and advance as if ready had arrived.
REQ-033 Without LOGIC_PROBE_SEQ_TIMEOUT_EN: WAIT SHALL wait indefinitely, no timeout counter SHALL be synthesized, and error SHALL be constant 0.

Verification
REQ-034 Normal capture: enable=1; pulse probe_interrupt; probe model returns 0x11110000+addr one cycle after each request -> five requests at addresses 0..4, one clear pulse, result_valid=1, host reads of 0..4 return 0x11110000..0x11110004, and address 5 shows capture_count=1.
REQ-035 Overrun: two captures without host_ack -> overrun=1 and the bank holds the second capture's data; host_ack -> result_valid=0 and overrun=0.
REQ-036 Atomicity: host repeatedly reads address 0 during the second capture -> the first value is returned until the CLEAR cycle, then only the new value.
REQ-037 Reset mid-WAIT at index 2 -> all outputs 0 immediately (asynchronous), no clear pulse is issued, and capture_count=0.
REQ-038 Timeout (macro defined): the probe never answers address 3 -> after 16 cycles shadow[3]=0xFFFFFFFF, error=1, and the sequence completes with a clear pulse.
REQ-039 Enable dropped in WAIT at index 1 -> the sequence completes; a subsequent probe_interrupt is ignored until enable=1.

Source files
------------

// File: rtl/logic_probe_sequencer.sv
// Reads NUM_REGS probe registers after each probe interrupt and publishes them as an atomic host-visible snapshot.
// Optional ready-wait timeout is built only when LOGIC_PROBE_SEQ_TIMEOUT_EN is defined.
module logic_probe_sequencer #(
    parameter int NUM_REGS       = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        probe_interrupt,
    output logic        probe_interrupt_clear,
    output logic [2:0]  probe_address,
    output logic        probe_data_request,
    input  logic        probe_data_ready,
    input  logic [31:0] probe_data,
    input  logic [2:0]  host_address,
    input  logic        host_read,
    output logic [31:0] host_data,
    output logic        host_ready,
    input  logic        host_ack,
    output logic        result_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;
    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    // Out-of-range configurations leave this marker block in the elaborated hierarchy.
    if (NUM_REGS < 1 || NUM_REGS > 5 || TIMEOUT_CYCLES < 1) begin : g_params_out_of_range
    end

    logic [1:0]  r_state;
    logic [2:0]  r_index;
    logic        r_holdoff;
    logic        r_result_valid;
    logic        r_overrun;
    logic [15:0] r_capture_count;
    logic [31:0] r_shadow [0:NUM_REGS-1];
    logic [31:0] r_bank   [0:NUM_REGS-1];
    logic        r_host_ready;
    logic [31:0] r_host_data;

    logic        w_timeout;
    logic        w_error;
    logic        w_advance;
    logic [31:0] w_capture_word;
    logic [31:0] w_host_word;

`ifdef LOGIC_PROBE_SEQ_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;
    logic             r_error;

    assign w_timeout = (r_state == S_WAIT) && !probe_data_ready &&
                       (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_error   = r_error;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_timer <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state != S_WAIT || probe_data_ready)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
            if (w_timeout)
                r_error <= 1'b1;
            else if (host_ack)
                r_error <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_error   = 1'b0;
`endif

    assign w_advance      = (r_state == S_WAIT) && (probe_data_ready || w_timeout);
    assign w_capture_word = probe_data_ready ? probe_data : 32'hFFFF_FFFF;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state         <= S_IDLE;
            r_index         <= '0;
            r_holdoff       <= 1'b0;
            r_result_valid  <= 1'b0;
            r_overrun       <= 1'b0;
            r_capture_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
                r_bank[i]   <= '0;
            end
        end else begin
            // CLEAR owns result_valid/overrun in its cycle, so an ack there is dropped.
            if (host_ack && r_state != S_CLEAR) begin
                r_result_valid <= 1'b0;
                r_overrun      <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_holdoff <= 1'b0;
                    if (enable && probe_interrupt && !r_holdoff) begin
                        r_state <= S_REQ;
                        r_index <= '0;
                    end
                end
                S_REQ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_advance) begin
                        r_shadow[r_index] <= w_capture_word;
                        if (r_index == LAST_IDX) begin
                            r_state <= S_CLEAR;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state         <= S_IDLE;
                    r_index         <= '0;
                    r_holdoff       <= 1'b1;
                    r_bank          <= r_shadow;
                    r_capture_count <= r_capture_count + 1'b1;
                    r_result_valid  <= 1'b1;
                    if (r_result_valid)
                        r_overrun <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_host_word = '0;
        if (host_address < 3'(NUM_REGS))
            w_host_word = r_bank[host_address];
        else if (host_address == 3'd5)
            w_host_word = {12'h0, w_error, r_overrun, r_result_valid, enable, r_capture_count};
    end

    // Host path reads only the bank register, which changes in a single edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_host_ready <= 1'b0;
            r_host_data  <= '0;
        end else begin
            r_host_ready <= host_read;
            if (host_read)
                r_host_data <= w_host_word;
        end
    end

    assign probe_data_request    = (r_state == S_REQ);
    assign probe_interrupt_clear = (r_state == S_CLEAR);
    assign probe_address         = r_index;
    assign result_valid          = r_result_valid;
    assign host_ready            = r_host_ready;
    assign host_data             = r_host_data;

endmodule

// File: tb/tb_logic_probe_sequencer.sv
// Scoreboard bench for logic_probe_sequencer: host reads queue expected words, a monitor checks each host_ready.
module tb_logic_probe_sequencer;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic        probe_interrupt;
    logic        probe_interrupt_clear;
    logic [2:0]  probe_address;
    logic        probe_data_request;
    logic        probe_data_ready = 1'b0;
    logic [31:0] probe_data = '0;
    logic [2:0]  host_address;
    logic        host_read;
    logic [31:0] host_data;
    logic        host_ready;
    logic        host_ack;
    logic        result_valid;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          clr_cnt = 0;
    int          clr_snap;
    logic [31:0] exp_q [$];
    logic [2:0]  req_q [$];
    logic [31:0] data_base = '0;
    logic        mute3 = 1'b0;

    always #5 clk = ~clk;

    logic_probe_sequencer dut (
        .clk                   (clk),
        .nreset                (nreset),
        .enable                (enable),
        .probe_interrupt       (probe_interrupt),
        .probe_interrupt_clear (probe_interrupt_clear),
        .probe_address         (probe_address),
        .probe_data_request    (probe_data_request),
        .probe_data_ready      (probe_data_ready),
        .probe_data            (probe_data),
        .host_address          (host_address),
        .host_read             (host_read),
        .host_data             (host_data),
        .host_ready            (host_ready),
        .host_ack              (host_ack),
        .result_valid          (result_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Probe model: answers one cycle after each request with base + address.
    always @(posedge clk) begin
        probe_data_ready <= 1'b0;
        if (probe_data_request && !(mute3 && probe_address == 3'd3)) begin
            probe_data_ready <= 1'b1;
            probe_data       <= data_base + {29'd0, probe_address};
        end
    end

    // Monitor: records probe activity and checks every host response against the scoreboard.
    always @(negedge clk) begin
        if (probe_data_request) req_q.push_back(probe_address);
        if (probe_interrupt_clear) clr_cnt++;
        if (host_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL host_unexpected: got 0x%08h, required no response", host_data);
            end else begin
                chk("host_data", host_data, exp_q.pop_front());
            end
        end
    end

    task automatic host_rd(input logic [2:0] addr, input logic [31:0] exp);
        host_address = addr;
        host_read    = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        host_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reqs(input int n);
        chk("req_count", 32'(req_q.size()), 32'(n));
        for (int i = 0; i < req_q.size() && i < n; i++)
            chk("req_addr", 32'(req_q[i]), 32'(i));
        req_q.delete();
    endtask

    // One capture; k counts edges after the trigger, CLEAR completes at edge 12.
    task automatic capture(input logic [31:0] base, input bit atomic, input logic [31:0] old_word,
                           input int ack_k, input int drop_en_k);
        data_base       = base;
        probe_interrupt = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            host_ack = (k == ack_k);
            if (k == drop_en_k) enable = 1'b0;
            if (atomic) begin
                host_address = 3'd0;
                host_read    = 1'b1;
                exp_q.push_back(k <= 12 ? old_word : base);
            end
            @(posedge clk); #1;
            probe_interrupt = 1'b0;
        end
        host_read = 1'b0;
        host_ack  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0; enable = 1'b1; probe_interrupt = 1'b0;
        host_address = 3'd0; host_read = 1'b0; host_ack = 1'b0;
        #12;
        chk("rst_request", 32'(probe_data_request), 32'd0);
        chk("rst_clear",   32'(probe_interrupt_clear), 32'd0);
        chk("rst_address", 32'(probe_address), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_host_data", host_data, 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        @(posedge clk); #1;
        host_rd(3'd5, 32'h0001_0000);

        // Normal capture
        capture(32'h1111_0000, 1'b0, 32'h0, 0, 0);
        check_reqs(5);
        chk("clear_pulses_1", 32'(clr_cnt), 32'd1);
        chk("result_valid_1", 32'(result_valid), 32'd1);
        for (int i = 0; i < 5; i++) host_rd(3'(i), 32'h1111_0000 + 32'(i));
        host_rd(3'd5, 32'h0003_0001);
        host_rd(3'd6, 32'h0);
        host_rd(3'd7, 32'h0);

        // Second capture without ack: overrun plus atomic reads of address 0
        capture(32'h2222_0000, 1'b1, 32'h1111_0000, 0, 0);
        check_reqs(5);
        chk("clear_pulses_2", 32'(clr_cnt), 32'd2);
        for (int i = 1; i < 5; i++) host_rd(3'(i), 32'h2222_0000 + 32'(i));
        host_rd(3'd5, 32'h0007_0002);
        host_ack = 1'b1; @(posedge clk); #1; host_ack = 1'b0;
        chk("ack_result_valid", 32'(result_valid), 32'd0);
        host_rd(3'd5, 32'h0001_0002);

        // Ack coincident with CLEAR, first with result_valid low, then high
        capture(32'h3333_0000, 1'b0, 32'h0, 12, 0);
        check_reqs(5);
        host_rd(3'd5, 32'h0003_0003);
        capture(32'h4444_0000, 1'b0, 32'h0, 12, 0);
        check_reqs(5);
        host_rd(3'd5, 32'h0007_0004);
        host_rd(3'd2, 32'h4444_0002);
        host_ack = 1'b1; @(posedge clk); #1; host_ack = 1'b0;
        host_rd(3'd5, 32'h0001_0004);

        // Enable dropped while waiting on index 1
        capture(32'h5555_0000, 1'b0, 32'h0, 0, 5);
        check_reqs(5);
        host_rd(3'd5, 32'h0002_0005);
        host_rd(3'd4, 32'h5555_0004);
        probe_interrupt = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("disabled_no_req", 32'(req_q.size()), 32'd0);
        data_base = 32'h6666_0000;
        host_ack = 1'b1; enable = 1'b1;
        @(posedge clk); #1;
        host_ack = 1'b0; probe_interrupt = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check_reqs(5);
        chk("clear_pulses_6", 32'(clr_cnt), 32'd6);
        host_rd(3'd5, 32'h0003_0006);
        host_rd(3'd4, 32'h6666_0004);
        host_ack = 1'b1; @(posedge clk); #1; host_ack = 1'b0;

`ifdef LOGIC_PROBE_SEQ_TIMEOUT_EN
        mute3 = 1'b1; data_base = 32'h7777_0000;
        probe_interrupt = 1'b1;
        @(posedge clk); #1;
        probe_interrupt = 1'b0;
        for (int i = 0; i < 100 && !result_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("timeout_done", 32'(result_valid), 32'd1);
        host_rd(3'd3, 32'hFFFF_FFFF);
        host_rd(3'd2, 32'h7777_0002);
        host_rd(3'd5, 32'h000B_0007);
        host_ack = 1'b1; @(posedge clk); #1; host_ack = 1'b0;
        mute3 = 1'b0;
        req_q.delete();
`endif

        // Reset while waiting on index 2
        clr_snap = clr_cnt;
        data_base = 32'h8888_0000;
        probe_interrupt = 1'b1;
        @(posedge clk); #1;
        probe_interrupt = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_wait_index", 32'(probe_address), 32'd2);
        chk("mid_wait_reqs", 32'(req_q.size()), 32'd3);
        req_q.delete();
        nreset = 1'b0;
        #1;
        chk("async_rst_address", 32'(probe_address), 32'd0);
        chk("async_rst_request", 32'(probe_data_request), 32'd0);
        chk("async_rst_clear", 32'(probe_interrupt_clear), 32'd0);
        chk("async_rst_result_valid", 32'(result_valid), 32'd0);
        chk("async_rst_host_data", host_data, 32'd0);
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_no_req", 32'(req_q.size()), 32'd0);
        chk("post_rst_no_clear", 32'(clr_cnt), 32'(clr_snap));
        host_rd(3'd5, 32'h0001_0000);
        host_rd(3'd0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
